tl_ul_monitor: RTL and testbench
================================

TL_UL_MONITOR -- requirements
Module: tl_ul_monitor

Interface
REQ-001 Parameter SOURCE_W, default 2: source ID width; table depth is 2^SOURCE_W.
REQ-002 Parameter ADDR_W, default 30: address width.
REQ-003 Parameter SIZE_W, default 3: size field width.
REQ-004 Parameter BEAT_LOG2, default 2: log2 beat bytes; mask width MW = 2^BEAT_LOG2.
REQ-005 Parameter MAX_SIZE_LOG2, default 6: largest legal transfer size.
REQ-006 Parameter TIMEOUT, default 1024: cycles allowed per outstanding request.
REQ-007 Single clock, reset asynchronous active-high; ports listed as name direction width meaning.
REQ-008 clock  in  1  sampling clock.
REQ-009 reset  in  1  async active-high reset.
REQ-010 a_valid, a_ready  in  1 each  A-channel handshake.
REQ-011 a_opcode  in  3; a_param  in  3; a_size  in  SIZE_W; a_source  in  SOURCE_W; a_address  in  ADDR_W; a_mask  in  MW.
REQ-012 d_valid, d_ready  in  1 each  D-channel handshake.
REQ-013 d_opcode  in  3; d_param  in  2; d_size  in  SIZE_W; d_source  in  SOURCE_W; d_denied, d_corrupt  in  1 each.
REQ-014 err_valid  out  1  one-cycle pulse on detected violation.
REQ-015 err_code  out  4  code of the violation flagged this cycle; 0 when err_valid low.
REQ-016 err_sticky  out  1  set on first violation, held until reset.
REQ-017 inflight_cnt  out  SOURCE_W+1  number of sources outstanding.

Function
REQ-018 A fire = a_valid&a_ready; D fire = d_valid&d_ready; all checks registered, err_valid asserted exactly 1 cycle after offending cycle.
REQ-019 Legal A opcodes: PutFullData 0, PutPartialData 1, Get 4; others -> code 1.
REQ-020 a_address not aligned to 2^a_size -> code 2.
REQ-021 Get/PutFullData with a_mask not equal to the full lane mask for size and address -> code 3; PutPartialData mask outside that lane mask -> code 3.
REQ-022 a_size > MAX_SIZE_LOG2 or a_param != 0 -> code 4.
REQ-023 First A beat for a source already in flight -> code 5, except when the same cycle retires that source (last D beat fire), which is legal and reloads the entry.
REQ-024 Put beats = 2^(a_size-BEAT_LOG2) when a_size > BEAT_LOG2, else 1; Get always 1; beat counter tracks A burst; opcode, size, source, address changing mid-burst -> code 6.
REQ-025 a_valid high without a_ready, next cycle a_valid low or any A field changed -> code 12; same rule on D -> code 13.
REQ-026 D fire with d_source not in flight -> code 7.
REQ-027 Expected response: Get -> AccessAckData 1; Put -> AccessAck 0; mismatch -> code 8; d_size != recorded size or d_param != 0 -> code 9.
REQ-028 AccessAckData beats counted as in REQ-024; opcode, size, source changing mid-burst -> code 10; d_corrupt with AccessAck -> code 9.
REQ-029 Entry (valid, opcode, size) written on first A beat fire, cleared on last D beat fire.
REQ-030 Multiple violations in one cycle: lowest code reported; err_sticky set regardless.
REQ-031 inflight_cnt updates the cycle after fire; simultaneous allocate and retire leave it unchanged.

Reset
REQ-032 On reset: all table entries invalid, beat counters 0, timers 0, err_valid 0, err_code 0, err_sticky 0, inflight_cnt 0.
REQ-033 Reset asserted mid-burst aborts tracking; first beat after release is treated as a new first beat.

Configuration
REQ-034 Macro TL_MONITOR_TIMEOUT_EN defined: per-source counter increments each cycle while valid, clears on retire; reaching TIMEOUT -> code 11 once per entry.
REQ-035 Macro undefined: no timeout counters instantiated, code 11 never produced.

Verification
REQ-036 Get size 2, addr 0x10, mask 0xF, source 1; AccessAckData source 1 size 2 -> no error, inflight_cnt 1 then 0.
REQ-037 PutFullData size 4 (4 beats), address changes on beat 2 -> err_valid pulse, err_code 6, err_sticky 1.
REQ-038 Get source 2 outstanding; second Get source 2 -> code 5; same repeated on the retire cycle -> no error.
REQ-039 D AccessAck on source 3 with nothing in flight -> code 7; Get at addr 0x2 size 2 -> code 2.
REQ-040 With TL_MONITOR_TIMEOUT_EN, TIMEOUT 16: Get unanswered 16 cycles -> single code 11 pulse; without macro -> none.

Source files
------------

// File: rtl/tl_ul_monitor_if.sv
// TileLink-UL A/D channel bundle observed by tl_ul_monitor.
// master drives every field; slave (the monitor) only observes.
interface tl_ul_monitor_if #(
  parameter int unsigned SOURCE_W  = 2,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned BEAT_LOG2 = 2
);
  localparam int unsigned MW = 1 << BEAT_LOG2;

  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SIZE_W-1:0]   a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [MW-1:0]       a_mask;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [SIZE_W-1:0]   d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic                d_corrupt;

  modport master (
    output a_valid, a_ready, a_opcode, a_param, a_size, a_source, a_address, a_mask,
    output d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt
  );

  modport slave (
    input a_valid, a_ready, a_opcode, a_param, a_size, a_source, a_address, a_mask,
    input d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt
  );
endinterface

// File: rtl/tl_ul_monitor.sv
// TileLink-UL protocol checker: per-source in-flight table, burst tracking, registered error codes.
// Optional per-source response timeout is enabled by defining TL_MONITOR_TIMEOUT_EN.
module tl_ul_monitor #(
  parameter int unsigned SOURCE_W      = 2,
  parameter int unsigned ADDR_W        = 30,
  parameter int unsigned SIZE_W        = 3,
  parameter int unsigned BEAT_LOG2     = 2,
  parameter int unsigned MAX_SIZE_LOG2 = 6,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                clock,
  input  logic                reset,
  tl_ul_monitor_if.slave      tl,
  output logic                err_valid,
  output logic [3:0]          err_code,
  output logic                err_sticky,
  output logic [SOURCE_W:0]   inflight_cnt
);
  localparam int unsigned MW    = 1 << BEAT_LOG2;
  localparam int unsigned DEPTH = 1 << SOURCE_W;
  localparam int unsigned BW    = 1 << SIZE_W;
  localparam int unsigned AF_W  = 6 + SIZE_W + SOURCE_W + ADDR_W + MW;
  localparam int unsigned DF_W  = 7 + SIZE_W + SOURCE_W;
  localparam logic [SOURCE_W:0] CNT_ONE = 1;

  typedef logic [BW-1:0] beat_t;
  typedef enum logic [2:0] {PUT_FULL = 3'd0, PUT_PARTIAL = 3'd1, GET = 3'd4} a_op_e;
  typedef enum logic [2:0] {ACCESS_ACK = 3'd0, ACCESS_ACK_DATA = 3'd1} d_op_e;

  function automatic beat_t last_idx(input logic burst, input logic [SIZE_W-1:0] size);
    beat_t one;
    one = beat_t'(1);
    if (burst && (int'(size) > int'(BEAT_LOG2)))
      return (one << (int'(size) - int'(BEAT_LOG2))) - one;
    return '0;
  endfunction

  function automatic logic [MW-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                              input logic [BEAT_LOG2-1:0] lo);
    logic [MW-1:0] m;
    for (int unsigned i = 0; i < MW; i++)
      m[i] = (int'(size) >= int'(BEAT_LOG2)) || ((i >> size) == (32'(lo) >> size));
    return m;
  endfunction

  function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                      input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] m;
    for (int unsigned i = 0; i < ADDR_W; i++) m[i] = (i < 32'(size));
    return |(addr & m);
  endfunction

  logic                ent_valid [DEPTH];
  logic [2:0]          ent_op    [DEPTH];
  logic [SIZE_W-1:0]   ent_size  [DEPTH];

  beat_t               a_cnt, a_last, d_cnt, d_last;
  logic [2:0]          a_op_q, d_op_q;
  logic [SIZE_W-1:0]   a_size_q, d_size_q;
  logic [SOURCE_W-1:0] a_src_q, d_src_q;
  logic [ADDR_W-1:0]   a_addr_q;
  logic                a_stall_q, d_stall_q;
  logic [AF_W-1:0]     a_fields, a_fields_q;
  logic [DF_W-1:0]     d_fields, d_fields_q;

  logic                a_fire, d_fire, a_first, d_first, a_put;
  logic                a_last_now, d_last_now, retire, reload, alloc, to_viol;
  logic [SOURCE_W-1:0] d_src;
  logic [MW-1:0]       lm;
  logic [13:1]         viol;
  logic [3:0]          code_nxt;

  assign a_fire   = tl.a_valid & tl.a_ready;
  assign d_fire   = tl.d_valid & tl.d_ready;
  assign a_first  = (a_cnt == '0);
  assign d_first  = (d_cnt == '0);
  assign a_put    = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);
  assign a_fields = {tl.a_opcode, tl.a_param, tl.a_size, tl.a_source, tl.a_address, tl.a_mask};
  assign d_fields = {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_denied, tl.d_corrupt};
  assign lm       = lane_mask(tl.a_size, tl.a_address[BEAT_LOG2-1:0]);

  assign a_last_now = a_first ? (last_idx(a_put, tl.a_size) == '0) : (a_cnt == a_last);
  assign d_last_now = d_first ? (last_idx(tl.d_opcode == ACCESS_ACK_DATA, tl.d_size) == '0)
                              : (d_cnt == d_last);
  // Mid-burst D beats retire the source captured on the first beat, not the bus value.
  assign d_src  = d_first ? tl.d_source : d_src_q;
  assign retire = d_fire && ent_valid[d_src] && d_last_now;
  assign reload = retire && (d_src == tl.a_source);
  assign alloc  = a_fire && a_first && (!ent_valid[tl.a_source] || reload);

  always_comb begin
    viol = '0;
    if (a_fire) begin
      viol[1] = !(a_put || (tl.a_opcode == GET));
      viol[2] = a_first && misaligned(tl.a_size, tl.a_address);
      if (tl.a_opcode == PUT_PARTIAL)
        viol[3] = |(tl.a_mask & ~lm);
      else if ((tl.a_opcode == PUT_FULL) || (tl.a_opcode == GET))
        viol[3] = (tl.a_mask != lm);
      viol[4] = (32'(tl.a_size) > MAX_SIZE_LOG2) || (tl.a_param != '0);
      viol[5] = a_first && ent_valid[tl.a_source] && !reload;
      viol[6] = !a_first && ((tl.a_opcode != a_op_q) || (tl.a_size != a_size_q) ||
                             (tl.a_source != a_src_q) || (tl.a_address != a_addr_q));
    end
    if (d_fire) begin
      if (d_first) begin
        viol[7] = !ent_valid[tl.d_source];
        if (ent_valid[tl.d_source]) begin
          viol[8] = (tl.d_opcode != ((ent_op[tl.d_source] == GET) ? ACCESS_ACK_DATA : ACCESS_ACK));
          viol[9] = (tl.d_size != ent_size[tl.d_source]);
        end
      end else begin
        viol[10] = (tl.d_opcode != d_op_q) || (tl.d_size != d_size_q) || (tl.d_source != d_src_q);
      end
      if ((tl.d_param != '0) || (tl.d_corrupt && (tl.d_opcode == ACCESS_ACK)))
        viol[9] = 1'b1;
    end
    viol[11] = to_viol;
    viol[12] = a_stall_q && (!tl.a_valid || (a_fields != a_fields_q));
    viol[13] = d_stall_q && (!tl.d_valid || (d_fields != d_fields_q));
  end

  always_comb begin
    code_nxt = '0;
    for (int i = 13; i >= 1; i--)
      if (viol[i]) code_nxt = 4'(i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_code     <= '0;
      err_sticky   <= 1'b0;
      inflight_cnt <= '0;
      a_stall_q    <= 1'b0;
      d_stall_q    <= 1'b0;
      a_fields_q   <= '0;
      d_fields_q   <= '0;
    end else begin
      err_valid  <= |viol;
      err_code   <= code_nxt;
      err_sticky <= err_sticky | (|viol);
      if (alloc && !retire)      inflight_cnt <= inflight_cnt + CNT_ONE;
      else if (retire && !alloc) inflight_cnt <= inflight_cnt - CNT_ONE;
      a_stall_q  <= tl.a_valid & ~tl.a_ready;
      d_stall_q  <= tl.d_valid & ~tl.d_ready;
      a_fields_q <= a_fields;
      d_fields_q <= d_fields;
    end
  end

  // Retire clears first so a same-cycle reload of that source leaves it valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_op[i]    <= '0;
        ent_size[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (retire && (d_src == SOURCE_W'(i))) ent_valid[i] <= 1'b0;
        if (alloc && (tl.a_source == SOURCE_W'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_op[i]    <= tl.a_opcode;
          ent_size[i]  <= tl.a_size;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_cnt    <= '0;
      a_last   <= '0;
      a_op_q   <= '0;
      a_size_q <= '0;
      a_src_q  <= '0;
      a_addr_q <= '0;
      d_cnt    <= '0;
      d_last   <= '0;
      d_op_q   <= '0;
      d_size_q <= '0;
      d_src_q  <= '0;
    end else begin
      if (a_fire) begin
        if (a_first) begin
          a_op_q   <= tl.a_opcode;
          a_size_q <= tl.a_size;
          a_src_q  <= tl.a_source;
          a_addr_q <= tl.a_address;
          a_last   <= last_idx(a_put, tl.a_size);
          if (!a_last_now) a_cnt <= beat_t'(1);
        end else begin
          a_cnt <= a_last_now ? '0 : a_cnt + beat_t'(1);
        end
      end
      if (d_fire) begin
        if (d_first) begin
          d_op_q   <= tl.d_opcode;
          d_size_q <= tl.d_size;
          d_src_q  <= tl.d_source;
          d_last   <= last_idx(tl.d_opcode == ACCESS_ACK_DATA, tl.d_size);
          if (!d_last_now && ent_valid[tl.d_source]) d_cnt <= beat_t'(1);
        end else begin
          d_cnt <= d_last_now ? '0 : d_cnt + beat_t'(1);
        end
      end
    end
  end

`ifdef TL_MONITOR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer [DEPTH];

  // Timer stops at TIMEOUT, so each entry can flag at most once.
  always_comb begin
    to_viol = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ent_valid[i] && (timer[i] == TW'(TIMEOUT - 1)) && !(retire && (d_src == SOURCE_W'(i))))
        to_viol = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) timer[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((retire && (d_src == SOURCE_W'(i))) || (alloc && (tl.a_source == SOURCE_W'(i))))
          timer[i] <= '0;
        else if (ent_valid[i] && (timer[i] != TW'(TIMEOUT)))
          timer[i] <= timer[i] + TW'(1);
      end
    end
  end
`else
  assign to_viol = (TIMEOUT == 0) && 1'b0;
`endif
endmodule

// File: tb/tb_tl_ul_monitor.sv
// Directed bench for tl_ul_monitor: one beat per call, error outputs sampled 1ns after the edge.
module tb_tl_ul_monitor;
  localparam int unsigned SW = 2, AW = 30, ZW = 3, BL = 2;
  localparam logic [2:0] PUT_FULL = 3'd0, PUT_PART = 3'd1, GET = 3'd4;
  localparam logic [2:0] ACK = 3'd0, ACK_DATA = 3'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_valid;
  logic [3:0]    err_code;
  logic          err_sticky;
  logic [SW:0]   inflight_cnt;
  int            tests = 0;
  int            failed = 0;
  int            pulses, first_at;

  tl_ul_monitor_if #(.SOURCE_W(SW), .ADDR_W(AW), .SIZE_W(ZW), .BEAT_LOG2(BL)) bus ();

  tl_ul_monitor #(
    .SOURCE_W(SW), .ADDR_W(AW), .SIZE_W(ZW), .BEAT_LOG2(BL),
    .MAX_SIZE_LOG2(6), .TIMEOUT(16)
  ) dut (
    .clock(clk), .reset(rst), .tl(bus.slave),
    .err_valid(err_valid), .err_code(err_code),
    .err_sticky(err_sticky), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic v, input logic [3:0] c);
    check({tag, ".valid"}, 32'(err_valid), 32'(v));
    check({tag, ".code"}, 32'(err_code), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 0; bus.a_ready = 1; bus.a_opcode = 0; bus.a_param = 0; bus.a_size = 0;
    bus.a_source = 0; bus.a_address = 0; bus.a_mask = 0;
    bus.d_valid = 0; bus.d_ready = 1; bus.d_opcode = 0; bus.d_param = 0; bus.d_size = 0;
    bus.d_source = 0; bus.d_denied = 0; bus.d_corrupt = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [ZW-1:0] sz, input logic [SW-1:0] src,
                         input logic [AW-1:0] addr, input logic [3:0] mask, input logic [2:0] prm);
    bus.a_valid = 1; bus.a_ready = 1; bus.a_opcode = op; bus.a_size = sz;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask; bus.a_param = prm;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [ZW-1:0] sz, input logic [SW-1:0] src,
                         input logic [1:0] prm, input logic cor);
    bus.d_valid = 1; bus.d_ready = 1; bus.d_opcode = op; bus.d_size = sz;
    bus.d_source = src; bus.d_param = prm; bus.d_corrupt = cor; bus.d_denied = 0;
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [ZW-1:0] sz, input logic [SW-1:0] src,
                        input logic [AW-1:0] addr, input logic [3:0] mask, input logic [2:0] prm = 0);
    drive_a(op, sz, src, addr, mask, prm);
    tick();
    bus.a_valid = 0;
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [ZW-1:0] sz, input logic [SW-1:0] src,
                        input logic [1:0] prm = 0, input logic cor = 0);
    drive_d(op, sz, src, prm, cor);
    tick();
    bus.d_valid = 0;
  endtask

  initial begin
    idle();
    tick(); tick();
    check_err("reset", 0, 0);
    check("reset.sticky", 32'(err_sticky), 0);
    check("reset.inflight", 32'(inflight_cnt), 0);
    rst = 1'b0;
    tick();

    // Clean Get / AccessAckData
    a_beat(GET, 2, 1, 30'h10, 4'hF);
    check_err("get1", 0, 0);
    check("get1.inflight", 32'(inflight_cnt), 1);
    d_beat(ACK_DATA, 2, 1);
    check_err("get1.d", 0, 0);
    check("get1.d.inflight", 32'(inflight_cnt), 0);

    // 4-beat PutFullData with address change on third beat
    a_beat(PUT_FULL, 4, 0, 30'h40, 4'hF); check_err("put4.b0", 0, 0);
    a_beat(PUT_FULL, 4, 0, 30'h40, 4'hF); check_err("put4.b1", 0, 0);
    a_beat(PUT_FULL, 4, 0, 30'h50, 4'hF); check_err("put4.b2", 1, 6);
    check("put4.sticky", 32'(err_sticky), 1);
    a_beat(PUT_FULL, 4, 0, 30'h40, 4'hF); check_err("put4.b3", 0, 0);
    check("put4.sticky_hold", 32'(err_sticky), 1);
    d_beat(ACK, 4, 0); check_err("put4.d", 0, 0);
    check("put4.inflight", 32'(inflight_cnt), 0);
    reset_dut();
    check("rst.sticky", 32'(err_sticky), 0);

    // Duplicate source, then legal reuse on retire cycle
    a_beat(GET, 2, 2, 30'h0, 4'hF); check_err("dup.first", 0, 0);
    a_beat(GET, 2, 2, 30'h0, 4'hF); check_err("dup.second", 1, 5);
    drive_a(GET, 2, 2, 30'h0, 4'hF, 0);
    drive_d(ACK_DATA, 2, 2, 0, 0);
    tick();
    bus.a_valid = 0; bus.d_valid = 0;
    check_err("dup.reload", 0, 0);
    check("dup.reload.inflight", 32'(inflight_cnt), 1);
    d_beat(ACK_DATA, 2, 2); check_err("dup.d", 0, 0);
    check("dup.inflight", 32'(inflight_cnt), 0);

    // Unknown source response, misaligned address, multi-violation priority
    d_beat(ACK, 2, 3); check_err("nosrc", 1, 7);
    a_beat(GET, 2, 0, 30'h2, 4'hF); check_err("misalign", 1, 2);
    d_beat(ACK_DATA, 2, 0); check_err("misalign.d", 0, 0);
    a_beat(GET, 2, 1, 30'h2, 4'h3, 3'd1); check_err("prio", 1, 2);
    d_beat(ACK_DATA, 2, 1); check_err("prio.d", 0, 0);

    // Partial/narrow lane masks
    a_beat(PUT_PART, 1, 0, 30'h2, 4'hC); check_err("pp.ok", 0, 0);
    d_beat(ACK, 1, 0); check_err("pp.ok.d", 0, 0);
    a_beat(PUT_PART, 1, 0, 30'h2, 4'h3); check_err("pp.bad", 1, 3);
    d_beat(ACK, 1, 0);
    a_beat(PUT_FULL, 0, 1, 30'h3, 4'h8); check_err("pf0.ok", 0, 0);
    d_beat(ACK, 0, 1);
    a_beat(PUT_FULL, 0, 1, 30'h3, 4'h1); check_err("pf0.bad", 1, 3);
    d_beat(ACK, 0, 1);
    check("mask.inflight", 32'(inflight_cnt), 0);

    // Response content errors
    a_beat(GET, 2, 1, 30'h0, 4'hF);
    d_beat(ACK, 2, 1); check_err("dop", 1, 8);
    check("dop.inflight", 32'(inflight_cnt), 0);
    a_beat(GET, 2, 1, 30'h0, 4'hF);
    d_beat(ACK_DATA, 1, 1); check_err("dsize", 1, 9);
    a_beat(PUT_FULL, 2, 0, 30'h0, 4'hF);
    d_beat(ACK, 2, 0, 0, 1); check_err("corrupt", 1, 9);
    check("resp.inflight", 32'(inflight_cnt), 0);

    // Multi-beat AccessAckData with source change mid-burst
    a_beat(GET, 4, 1, 30'h0, 4'hF); check_err("rburst.a", 0, 0);
    d_beat(ACK_DATA, 4, 1); check_err("rburst.b0", 0, 0);
    check("rburst.mid.inflight", 32'(inflight_cnt), 1);
    d_beat(ACK_DATA, 4, 2); check_err("rburst.b1", 1, 10);
    d_beat(ACK_DATA, 4, 1); check_err("rburst.b2", 0, 0);
    d_beat(ACK_DATA, 4, 1); check_err("rburst.b3", 0, 0);
    check("rburst.inflight", 32'(inflight_cnt), 0);

    // Handshake stability
    drive_a(GET, 2, 0, 30'h0, 4'hF, 0); bus.a_ready = 0;
    tick(); check_err("astall.hold", 0, 0);
    bus.a_valid = 0;
    tick(); check_err("astall.drop", 1, 12);
    drive_a(GET, 2, 0, 30'h0, 4'hF, 0); bus.a_ready = 0;
    tick(); bus.a_ready = 1;
    tick(); bus.a_valid = 0;
    check_err("astall.ok", 0, 0);
    check("astall.inflight", 32'(inflight_cnt), 1);
    d_beat(ACK_DATA, 2, 0); check_err("astall.d", 0, 0);
    drive_d(ACK_DATA, 2, 0, 0, 0); bus.d_ready = 0;
    tick(); check_err("dstall.hold", 0, 0);
    bus.d_opcode = ACK;
    tick(); check_err("dstall.chg", 1, 13);
    bus.d_valid = 0; bus.d_ready = 1;
    tick(); check_err("dstall.drop", 1, 13);
    tick(); check_err("dstall.idle", 0, 0);

    // Illegal opcode and oversize, each followed by reset
    reset_dut();
    a_beat(3'd2, 2, 1, 30'h0, 4'hF); check_err("badop", 1, 1);
    reset_dut();
    a_beat(GET, 7, 1, 30'h0, 4'hF); check_err("oversize", 1, 4);

    // Reset mid-burst: next beat is a fresh first beat
    reset_dut();
    a_beat(PUT_FULL, 3, 0, 30'h0, 4'hF); check_err("rstmid.b0", 0, 0);
    reset_dut();
    a_beat(PUT_FULL, 2, 0, 30'h4, 4'hF); check_err("rstmid.new", 0, 0);
    check("rstmid.inflight", 32'(inflight_cnt), 1);
    d_beat(ACK, 2, 0); check_err("rstmid.d", 0, 0);

    // Timeout
    reset_dut();
    a_beat(GET, 2, 3, 30'h0, 4'hF); check_err("to.a", 0, 0);
    pulses = 0; first_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (err_valid && (err_code == 4'd11)) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
`ifdef TL_MONITOR_TIMEOUT_EN
    check("to.pulses", 32'(pulses), 1);
    check("to.at", 32'(first_at), 16);
    check("to.sticky", 32'(err_sticky), 1);
`else
    check("to.pulses", 32'(pulses), 0);
    check("to.sticky", 32'(err_sticky), 0);
`endif
    d_beat(ACK_DATA, 2, 3); check_err("to.d", 0, 0);
    check("to.inflight", 32'(inflight_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
